// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg -- shared definitions for the UART frame transmitter.
//   Frame marker bytes, address/data field widths, the frame FSM state
//   type and the helper that packs address/data fields into payload bytes.
package uart_frame_pkg;

   localparam logic [7:0] START_BYTE        = 8'hF5;
   localparam logic [7:0] STOP_BYTE         = 8'hFA;
   localparam logic [7:0] READ_OUT_MEM_BYTE = 8'hF6;

   localparam int ADDR_W    = 10;
   localparam int DATA_W    = 12;
   localparam int ADDR_HI_W = 5;
   localparam int ADDR_LO_W = 5;
   localparam int DATA_HI_W = 6;
   localparam int DATA_LO_W = 6;

   localparam int NUM_PAYLOAD   = 4;   // payload bytes between START and STOP
   localparam int BITS_PER_CHAR = 10;  // 8N1: start + 8 data + stop

   typedef enum logic [1:0] {
      IDLE,
      SEND_START,
      SEND_PAYLOAD,
      SEND_STOP
   } frame_state_t;

   // Payload bytes carry at most 6 significant bits, so they can never
   // collide with the 0xF5 / 0xF6 / 0xFA marker bytes.
   function automatic logic [7:0] payload_byte(input logic [ADDR_W-1:0] addr,
                                               input logic [DATA_W-1:0] data,
                                               input logic [1:0]        idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = {3'b000, addr[ADDR_W-1 -: ADDR_HI_W]};
         2'd1:    b = {3'b000, addr[ADDR_LO_W-1:0]};
         2'd2:    b = {2'b00,  data[DATA_W-1 -: DATA_HI_W]};
         default: b = {2'b00,  data[DATA_LO_W-1:0]};
      endcase
      return b;
   endfunction

endpackage

// File: rtl/uart_frame_tx_byte.sv
// uart_tx_byte -- 8N1 byte serialiser with a baud counter.
//   clk, rst_n : clock / async active-low reset
//   byte_in    : byte to send, sampled when send is taken
//   send       : start a byte; taken when idle or in the last cycle of
//                the current stop bit (done), which chains bytes gap-free
//   ready      : serialiser idle
//   done       : last cycle of the current byte's stop bit
//   tx         : registered serial output, idle high
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] byte_in,
   input  logic       send,
   output logic       ready,
   output logic       done,
   output logic       tx
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);

   logic [CW-1:0] baud_cnt;
   logic [3:0]    bit_idx;   // 0 = start, 1..8 = data, 9 = stop
   logic [7:0]    shreg;
   logic          active;
   logic          bit_end;
   logic          load;

   assign bit_end = active && (baud_cnt == CW'(CLKS_PER_BIT - 1));
   assign done    = bit_end && (bit_idx == 4'd9);
   assign ready   = !active;
   assign load    = send && (!active || done);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active   <= 1'b0;
         tx       <= 1'b1;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
      end else if (load) begin
         active   <= 1'b1;
         tx       <= 1'b0;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= byte_in;
      end else if (active) begin
         if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 4'd9) begin
               active  <= 1'b0;
               tx      <= 1'b1;
               bit_idx <= '0;
            end else begin
               bit_idx <= bit_idx + 4'd1;
               if (bit_idx == 4'd8) begin
                  tx <= 1'b1;
               end else begin
                  tx    <= shreg[0];
                  shreg <= {1'b0, shreg[7:1]};
               end
            end
         end else begin
            baud_cnt <= baud_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx -- sends a memory address/data pair as a six-byte UART frame:
//   F5, addr[9:5], addr[4:0], data[11:6], data[5:0], FA (8N1, back-to-back).
//   clk, rst_n         : clock / async active-low reset
//   in_valid, in_ready : request handshake; in_addr / in_data captured on accept
//   tx                 : serial line, idle high
//   busy               : frame in progress
//   frame_done         : one-cycle pulse in the first idle cycle after a frame
module uart_frame_tx
   import uart_frame_pkg::*;
#(
   parameter int CLK_FREQ = 25000000,
   parameter int BAUD     = 115200
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

   generate
      if (CLKS_PER_BIT < 2) begin : g_cpb_check
         $error("uart_frame_tx: CLK_FREQ/BAUD must be at least 2");
      end
   endgenerate

   frame_state_t      state, state_nxt;
   logic [1:0]        idx, idx_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              frame_done_q;
   logic              accept;
   logic              send;
   logic [7:0]        byte_sel;
   logic              byte_ready;
   logic              byte_done;

   assign in_ready   = (state == IDLE) && byte_ready;
   assign accept     = in_valid && in_ready;
   assign busy       = (state != IDLE);
   assign frame_done = frame_done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx          <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state        <= state_nxt;
         idx          <= idx_nxt;
         frame_done_q <= (state == SEND_STOP) && byte_done;
         if (accept) begin
            addr_q <= in_addr;
            data_q <= in_data;
         end
      end
   end

   // The next byte is launched in the same cycle the previous one reports
   // done, so the serialiser never idles inside a frame.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      send      = 1'b0;
      byte_sel  = START_BYTE;
      case (state)
         IDLE: begin
            if (accept) begin
               send      = 1'b1;
               byte_sel  = START_BYTE;
               idx_nxt   = 2'd0;
               state_nxt = SEND_START;
            end
         end
         SEND_START: begin
            if (byte_done) begin
               send      = 1'b1;
               byte_sel  = payload_byte(addr_q, data_q, 2'd0);
               idx_nxt   = 2'd0;
               state_nxt = SEND_PAYLOAD;
            end
         end
         SEND_PAYLOAD: begin
            if (byte_done) begin
               send = 1'b1;
               if (idx == 2'(NUM_PAYLOAD - 1)) begin
                  byte_sel  = STOP_BYTE;
                  state_nxt = SEND_STOP;
               end else begin
                  byte_sel = payload_byte(addr_q, data_q, idx + 2'd1);
                  idx_nxt  = idx + 2'd1;
               end
            end
         end
         SEND_STOP: begin
            if (byte_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
      .clk     (clk),
      .rst_n   (rst_n),
      .byte_in (byte_sel),
      .send    (send),
      .ready   (byte_ready),
      .done    (byte_done),
      .tx      (tx)
   );

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx -- bench for uart_frame_tx: a UART receiver model decodes
// tx and compares each byte against a queue of expected bytes pushed when
// a request is driven; frame timing and reset behaviour are checked inline.
module tb_uart_frame_tx;

   localparam int CPB      = 4;            // 1000 Hz / 250 baud
   localparam int BYTE_LEN = 10 * CPB;
   localparam int FRAME    = 60 * CPB;     // 240
   localparam int DEF_CPB  = 217;          // 25 MHz / 115200, truncated
   localparam int DEF_FRAME = 13020;

   typedef logic [5:0][7:0] frame_t;
   typedef struct {
      logic [9:0]  addr;
      logic [11:0] data;
      frame_t      exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, tx, busy, frame_done;
   logic [9:0]  in_addr;
   logic [11:0] in_data;
   logic        d_valid, d_ready, d_tx, d_busy, d_done;
   logic [9:0]  d_addr;
   logic [11:0] d_data;

   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   logic [7:0]  exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_frame_tx #(.CLK_FREQ(1000), .BAUD(250)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .tx(tx), .busy(busy),
      .frame_done(frame_done)
   );

   uart_frame_tx u_def (
      .clk(clk), .rst_n(rst_n), .in_valid(d_valid), .in_ready(d_ready),
      .in_addr(d_addr), .in_data(d_data), .tx(d_tx), .busy(d_busy),
      .frame_done(d_done)
   );

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic frame_t model(input logic [9:0] a, input logic [11:0] d);
      return {8'hFA, {2'b00, d[5:0]}, {2'b00, d[11:6]},
              {3'b000, a[4:0]}, {3'b000, a[9:5]}, 8'hF5};
   endfunction

   task automatic push_frame(input frame_t e);
      for (int i = 0; i < 6; i++) exp_q.push_back(e[i]);
   endtask

   // Waits for in_ready, presents one request, returns the cycle count seen
   // in the first cycle after acceptance; inputs are scrambled afterwards.
   task automatic send_req(input logic [9:0] a, input logic [11:0] d,
                           input frame_t e, output int acc);
      int n;
      n = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
      check("req_ready", in_ready, 1);
      in_valid = 1'b1; in_addr = a; in_data = d;
      push_frame(e);
      @(negedge clk);
      acc = cyc;
      in_valid = 1'b0; in_addr = ~a; in_data = ~d;
      check("start_bit_tx", tx, 0);
      check("busy_in_frame", busy, 1);
      check("ready_in_frame", in_ready, 0);
   endtask

   task automatic wait_done(input int acc, input string name);
      int n;
      n = 0;
      while (frame_done !== 1'b1 && n < FRAME + 50) begin @(negedge clk); n++; end
      check(name, cyc - acc, FRAME);
      check("done_tx_idle", tx, 1);
      check("done_ready", in_ready, 1);
      check("done_not_busy", busy, 0);
      @(negedge clk);
      check("done_pulse_width", frame_done, 0);
   endtask

   // UART receiver model: samples bit centres, drops any byte that overlaps reset.
   initial begin : mon
      logic [7:0] b;
      logic       stopb;
      bit         ab;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && tx === 1'b0) begin
            ab = 1'b0; b = '0;
            for (int i = 0; i < CPB / 2; i++) begin @(negedge clk); if (rst_n !== 1'b1) ab = 1'b1; end
            for (int k = 0; k < 8; k++) begin
               for (int i = 0; i < CPB; i++) begin @(negedge clk); if (rst_n !== 1'b1) ab = 1'b1; end
               b[k] = tx;
            end
            for (int i = 0; i < CPB; i++) begin @(negedge clk); if (rst_n !== 1'b1) ab = 1'b1; end
            stopb = tx;
            if (!ab) begin
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL rx_unexpected: got byte %02h want none", b);
               end else begin
                  check("rx_byte", b, exp_q.pop_front());
                  check("rx_stop", stopb, 1);
               end
            end
         end
      end
   end

   initial begin : main
      vec_t        vecs[4];
      int          acc, acc1, acc2, n, m;
      bit          got2, fd, rdy, fd_seen;
      logic [9:0]  a;
      logic [11:0] d;

      vecs[0] = '{addr: 10'h2A5, data: 12'hA5C, exp: 48'hFA_1C_29_05_15_F5};
      vecs[1] = '{addr: 10'h3FF, data: 12'hFFF, exp: 48'hFA_3F_3F_1F_1F_F5};
      vecs[2] = '{addr: 10'h000, data: 12'h000, exp: 48'hFA_00_00_00_00_F5};
      vecs[3] = '{addr: 10'h155, data: 12'h2AA, exp: 48'hFA_2A_0A_15_0A_F5};

      rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
      d_valid = 1'b0; d_addr = '0; d_data = '0;
      repeat (3) @(negedge clk);
      check("reset_tx", tx, 1);
      check("reset_busy", busy, 0);
      check("reset_done", frame_done, 0);
      check("reset_def_tx", d_tx, 1);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", in_ready, 1);

      // table-driven frames
      for (int v = 0; v < 4; v++) begin
         send_req(vecs[v].addr, vecs[v].data, vecs[v].exp, acc);
         wait_done(acc, "frame_len");
         check("all_bytes_rx", exp_q.size(), 0);
      end

      // in_valid held high with changing fields across a whole frame
      n = 0; got2 = 1'b0; acc1 = 0; acc2 = 0;
      @(negedge clk);
      in_valid = 1'b1;
      while (!got2 && n < FRAME + 50) begin
         fd = frame_done; rdy = in_ready;
         a = 10'($urandom); d = 12'($urandom);
         in_addr = a; in_data = d;
         if (rdy) begin
            push_frame(model(a, d));
            if (n == 0) begin
               acc1 = cyc + 1;
            end else begin
               check("b2b_accept_in_done_cycle", fd, 1);
               check("b2b_gap", cyc - acc1, FRAME);
               check("b2b_idle_tx", tx, 1);
               acc2 = cyc + 1;
               got2 = 1'b1;
            end
         end
         @(negedge clk);
         n++;
      end
      in_valid = 1'b0;
      check("b2b_accepted", got2, 1);
      check("b2b_second_start", tx, 0);
      wait_done(acc2, "b2b_frame2_len");
      check("b2b_all_rx", exp_q.size(), 0);

      // reset during payload byte 2 (data[11:6]), while tx is low
      send_req(10'h1C3, 12'h5A6, model(10'h1C3, 12'h5A6), acc);
      while (cyc < acc + 3 * BYTE_LEN + 17) @(negedge clk);
      check("pre_reset_busy", busy, 1);
      check("pre_reset_tx_low", tx, 0);
      rst_n = 1'b0;
      #1;
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      fd_seen = 1'b0;
      repeat (FRAME) begin @(negedge clk); if (frame_done === 1'b1) fd_seen = 1'b1; end
      check("rst_no_done", fd_seen, 0);
      check("rst_tx_idle", tx, 1);
      exp_q.delete();
      send_req(10'h0F0, 12'h3C3, model(10'h0F0, 12'h3C3), acc);
      wait_done(acc, "post_rst_frame_len");
      check("post_rst_all_rx", exp_q.size(), 0);

      // default parameters: bit width and frame length on the real baud
      @(negedge clk);
      check("def_ready", d_ready, 1);
      d_valid = 1'b1; d_addr = 10'h2A5; d_data = 12'hA5C;
      @(negedge clk);
      acc = cyc;
      d_valid = 1'b0;
      check("def_start_low", d_tx, 0);
      n = 0;
      while (d_tx === 1'b0 && n < 1000) begin @(negedge clk); n++; end
      check("def_start_bit_len", n, DEF_CPB);
      m = 0;
      while (d_tx === 1'b1 && m < 1000) begin @(negedge clk); m++; end
      check("def_bit0_len", m, DEF_CPB);
      n = 0;
      while (d_done !== 1'b1 && n < DEF_FRAME + 100) begin @(negedge clk); n++; end
      check("def_frame_len", cyc - acc, DEF_FRAME);
      check("def_done_tx", d_tx, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_frame_tx.md
UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25000000: clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200: serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, truncated.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: a frame request is present.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-007 SHALL have port in_addr, input, 10 bits: memory address to frame.
REQ-008 SHALL have port in_data, input, 12 bits: memory data word to frame.
REQ-009 SHALL have port tx, output, 1 bit: UART serial line, 8N1, idle high.
REQ-010 SHALL have port busy, output, 1 bit: a frame is being transmitted.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame completes.

Function
REQ-012 SHALL accept a request on any cycle with in_valid=1 and in_ready=1, capturing in_addr and in_data into internal registers.
REQ-013 SHALL assert in_ready only in state IDLE and SHALL ignore in_valid in all other states.
REQ-014 SHALL send each frame as six bytes in this order:
- 0xF5 (START)
- {3'b0, addr[9:5]}
- {3'b0, addr[4:0]}
- {2'b0, data[11:6]}
- {2'b0, data[5:0]}
- 0xFA (STOP)
REQ-015 SHALL serialise each byte as:
- one start bit (0), then
- 8 data bits, LSB first, then
- one stop bit (1).
Each bit SHALL be held for exactly CLKS_PER_BIT cycles.
REQ-016 SHALL place bytes back-to-back with no idle gap, giving a frame length of exactly 60*CLKS_PER_BIT cycles.
REQ-017 SHALL drive tx low for the start bit of 0xF5 starting in the cycle after acceptance.
REQ-018 SHALL implement the FSM with states IDLE, SEND_START, SEND_PAYLOAD (2-bit byte index 0..3) and SEND_STOP.
REQ-019 SHALL make FSM transitions as follows:
- IDLE -> SEND_START on acceptance.
- SEND_START -> SEND_PAYLOAD when its byte finishes.
- SEND_PAYLOAD advances the byte index per completed byte; index 3 done -> SEND_STOP.
- SEND_STOP done -> IDLE.
REQ-020 SHALL assert frame_done for exactly the first cycle of IDLE after SEND_STOP; in_ready is 1 in that cycle.
REQ-021 SHALL, when in_valid=1 during the frame_done cycle, accept it, leaving exactly one idle-high tx cycle between frames.
REQ-022 SHALL assert busy=1 in every non-IDLE state.
REQ-023 SHALL not let changes on in_addr/in_data after acceptance affect the frame in flight.
REQ-024 SHALL emit payload bytes that never equal 0xF5, 0xF6 or 0xFA (payload bytes are at most 0x3F).
REQ-025 SHALL, if CLKS_PER_BIT < 2, flag an elaboration-time error.

Reset
REQ-026 SHALL, while rst_n=0, force tx=1, busy=0, frame_done=0 and FSM=IDLE, and clear the bit/byte/baud counters.
REQ-027 SHALL, on reset asserted mid-frame, abandon the frame with tx high immediately (asynchronously) and no frame_done pulse.
REQ-028 SHALL hold in_ready=1 from the first clock edge after rst_n deasserts.

Structure
REQ-029 SHALL place in package uart_frame_pkg:
- START_BYTE=8'hF5, STOP_BYTE=8'hFA, READ_OUT_MEM_BYTE=8'hF6
- the FSM state enum
- payload byte-packing constants/widths
REQ-030 SHALL instantiate one sub-module, uart_tx_byte, which:
- performs 8N1 serialisation with a baud counter;
- has ports byte_in, send, ready, done and tx;
- is sequenced by the top FSM.

Verification (CLK_FREQ=1000, BAUD=250 -> CLKS_PER_BIT=4 unless noted)
REQ-031 SHALL cover: addr=0x2A5, data=0xA5C -> tx decodes F5 15 05 29 1C FA; frame_done exactly 240 cycles after acceptance.
REQ-032 SHALL cover: addr=0x3FF, data=0xFFF -> F5 1F 1F 3F 3F FA; addr=0, data=0 -> F5 00 00 00 00 FA.
REQ-033 SHALL cover: in_valid held high with changing addr/data during a frame -> first frame unchanged; second accepted only in the frame_done cycle; exactly one idle-high cycle between frames.
REQ-034 SHALL cover: rst_n pulsed low during payload byte 2 -> tx=1 immediately, busy=0, no frame_done; next request yields a clean full frame.
REQ-035 SHALL cover: defaults (25 MHz, 115200 baud) -> 217 cycles per bit measured on tx; 13020-cycle frame.
